// File: rtl/subtractor.sv
// Unsigned BITS-wide subtractor built from a ripple-borrow chain, with one
// registered output stage holding {borrow, difference}.
module subtractor #(
  parameter int BITS = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [BITS-1:0] i_minuend,
  input  logic [BITS-1:0] i_subtrahend,
  output logic [BITS-1:0] o_difference,
  output logic            o_borrow
);

  logic [BITS:0]   borrow_chain;
  logic [BITS-1:0] difference_d;
  logic [BITS-1:0] difference_q;
  logic            borrow_d;
  logic            borrow_q;

  // Full-subtractor cells; bit 0 starts with no borrow.
  always_comb begin
    borrow_chain = '0;
    difference_d = '0;
    for (int i = 0; i < BITS; i++) begin
      difference_d[i]   = i_minuend[i] ^ i_subtrahend[i] ^ borrow_chain[i];
      borrow_chain[i+1] = (~i_minuend[i] & i_subtrahend[i])
                        | (~(i_minuend[i] ^ i_subtrahend[i]) & borrow_chain[i]);
    end
    borrow_d = borrow_chain[BITS];
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      difference_q <= '0;
      borrow_q     <= 1'b0;
    end else begin
      difference_q <= difference_d;
      borrow_q     <= borrow_d;
    end
  end

  assign o_difference = difference_q;
  assign o_borrow     = borrow_q;

endmodule

// File: tb/tb_subtractor.sv
// Self-checking bench: drives 1-, 4- and 8-bit subtractors with the same
// operands (truncated to each width) and compares against x - y arithmetic.
module tb_subtractor;

  logic       i_clock;
  logic       i_reset;
  logic [0:0] x1, y1, d1;
  logic [3:0] x4, y4, d4;
  logic [7:0] x8, y8, d8;
  logic       b1, b4, b8;

  int checks = 0;
  int errors = 0;

  subtractor #(.BITS(1)) dut1 (
    .i_clock(i_clock), .i_reset(i_reset), .i_minuend(x1), .i_subtrahend(y1),
    .o_difference(d1), .o_borrow(b1)
  );
  subtractor #(.BITS(4)) dut4 (
    .i_clock(i_clock), .i_reset(i_reset), .i_minuend(x4), .i_subtrahend(y4),
    .o_difference(d4), .o_borrow(b4)
  );
  subtractor #(.BITS(8)) dut8 (
    .i_clock(i_clock), .i_reset(i_reset), .i_minuend(x8), .i_subtrahend(y8),
    .o_difference(d8), .o_borrow(b8)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Exact x - y (operands reduced to the given width), encoded as a
  // (bits+1)-bit two's-complement pattern.
  function automatic logic [31:0] refResult(input int x, input int y, input int bits);
    int m;
    int r;
    m = (1 << bits) - 1;
    r = (x & m) - (y & m);
    return 32'(r & ((1 << (bits + 1)) - 1));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", tag, observed, expected);
    end
  endtask

  // Present operands, clock one edge, then sample just after it.
  task automatic applyStimulus(input logic rst, input int x, input int y);
    i_reset = rst;
    x1 = 1'(x);
    y1 = 1'(y);
    x4 = 4'(x);
    y4 = 4'(y);
    x8 = 8'(x);
    y8 = 8'(y);
    @(posedge i_clock);
    #1;
  endtask

  task automatic checkAll(input logic rst, input int x, input int y);
    logic [31:0] e1, e4, e8;
    e1 = rst ? 32'd0 : refResult(x, y, 1);
    e4 = rst ? 32'd0 : refResult(x, y, 4);
    e8 = rst ? 32'd0 : refResult(x, y, 8);
    checkOutput($sformatf("w1 x=%0d y=%0d rst=%0d", x & 1, y & 1, rst), 32'({b1, d1}), e1);
    checkOutput($sformatf("w4 x=%0d y=%0d rst=%0d", x & 15, y & 15, rst), 32'({b4, d4}), e4);
    checkOutput($sformatf("w8 x=%0d y=%0d rst=%0d", x & 255, y & 255, rst), 32'({b8, d8}), e8);
  endtask

  task automatic step(input logic rst, input int x, input int y);
    applyStimulus(rst, x, y);
    checkAll(rst, x, y);
  endtask

  initial begin
    int dx [];
    int dy [];
    int rx;
    int ry;
    logic rr;

    i_reset = 1'b1;
    {x1, y1, x4, y4, x8, y8} = '0;

    // Reset with live operands, then release.
    step(1'b1, 9, 3);
    step(1'b0, 9, 3);
    checkOutput("reset_release w4 diff", 32'(d4), 32'd6);
    checkOutput("reset_release w4 borrow", 32'(b4), 32'd0);

    // Directed cases, including back-to-back stream and boundaries.
    dx = '{7, 15, 5, 3, 0, 0, 2, 9, 0, 0, 100, 255, 13};
    dy = '{3, 0, 5, 7, 15, 1, 9, 2, 0, 1, 200, 255, 0};
    foreach (dx[k]) step(1'b0, dx[k], dy[k]);

    // Hand-computed spot checks independent of the model.
    step(1'b0, 3, 7);
    checkOutput("3-7 w4", 32'({b4, d4}), 32'b1_1100);
    step(1'b0, 0, 15);
    checkOutput("0-15 w4", 32'({b4, d4}), 32'b1_0001);
    step(1'b0, 0, 1);
    checkOutput("0-1 w1", 32'({b1, d1}), 32'b11);
    checkOutput("0-1 w4", 32'({b4, d4}), 32'b1_1111);
    step(1'b0, 100, 200);
    checkOutput("100-200 w8", 32'({b8, d8}), 32'h100 + 32'd156);
    step(1'b0, 255, 255);
    checkOutput("255-255 w8", 32'({b8, d8}), 32'd0);

    // Exhaustive 4-bit space (also exercises the other widths).
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        step(1'b0, x, y);

    // Random stream with occasional mid-stream reset.
    for (int n = 0; n < 400; n++) begin
      rx = int'($urandom_range(0, 255));
      ry = int'($urandom_range(0, 255));
      rr = ($urandom_range(0, 15) == 0);
      step(rr, rx, ry);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
